// File: rtl/tri_l2_rr_arbiter_if.sv
// Bundle of the requester-side and downstream TRI L2 handshake signals around the arbiter.
// The arbiter uses the slave view; the surrounding requesters and L2 port use the master view.
interface tri_l2_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int TYPE_W  = 5,
  parameter int AMO_W   = 4
);
  logic [NUM_REQ-1:0]        in_req_valid;
  logic [NUM_REQ*TYPE_W-1:0] in_req_type;
  logic [NUM_REQ*AMO_W-1:0]  in_req_amo_op;
  logic [NUM_REQ*3-1:0]      in_req_size;
  logic [NUM_REQ*ADDR_W-1:0] in_req_addr;
  logic [NUM_REQ*DATA_W-1:0] in_req_data;
  logic [NUM_REQ-1:0]        in_req_ack;
  logic [NUM_REQ-1:0]        in_resp_val;
  logic [TYPE_W-1:0]         in_resp_type;
  logic [DATA_W-1:0]         in_resp_data;
  logic [NUM_REQ-1:0]        in_resp_ack;

  logic                      out_req_valid;
  logic [TYPE_W-1:0]         out_req_type;
  logic [AMO_W-1:0]          out_req_amo_op;
  logic [2:0]                out_req_size;
  logic [ADDR_W-1:0]         out_req_addr;
  logic [DATA_W-1:0]         out_req_data;
  logic                      out_req_ack;
  logic                      out_resp_val;
  logic [TYPE_W-1:0]         out_resp_type;
  logic [DATA_W-1:0]         out_resp_data;
  logic                      out_resp_ack;

  modport slave (
    input  in_req_valid, in_req_type, in_req_amo_op, in_req_size, in_req_addr, in_req_data,
    input  in_resp_ack,
    output in_req_ack, in_resp_val, in_resp_type, in_resp_data,
    output out_req_valid, out_req_type, out_req_amo_op, out_req_size, out_req_addr, out_req_data,
    input  out_req_ack, out_resp_val, out_resp_type, out_resp_data,
    output out_resp_ack
  );

  modport master (
    output in_req_valid, in_req_type, in_req_amo_op, in_req_size, in_req_addr, in_req_data,
    output in_resp_ack,
    input  in_req_ack, in_resp_val, in_resp_type, in_resp_data,
    input  out_req_valid, out_req_type, out_req_amo_op, out_req_size, out_req_addr, out_req_data,
    output out_req_ack, out_resp_val, out_resp_type, out_resp_data,
    input  out_resp_ack
  );
endinterface

// File: rtl/tri_l2_rr_arbiter.sv
// Round-robin arbiter sharing one TRI L2 port among NUM_REQ coherency units,
// one outstanding transaction at a time; ack and response are routed back to the winner only.
//
// state  | meaning
// S_IDLE | no transaction; pick winner from rr_ptr upward and latch its payload
// S_REQ  | latched request presented downstream; waiting for out_req_ack
// S_RESP | waiting for downstream response and the winner's response ack
module tri_l2_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int TYPE_W  = 5,
  parameter int AMO_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tri_l2_rr_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [TYPE_W-1:0]   req_type_q;
  logic [AMO_W-1:0]    req_amo_q;
  logic [2:0]          req_size_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand_sum;
  logic [IDX_W-1:0]    cand_idx;

  logic [TYPE_W-1:0]   sel_type;
  logic [AMO_W-1:0]    sel_amo;
  logic [2:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic [NUM_REQ-1:0]  grant_oh;
  logic [IDX_W-1:0]    next_ptr;
  logic                resp_done;

  // Search starts at rr_ptr and wraps, so the last-served requester ends up with lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (!win_found && bus.in_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_type = '0;
    sel_amo  = '0;
    sel_size = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_type = bus.in_req_type[i*TYPE_W +: TYPE_W];
        sel_amo  = bus.in_req_amo_op[i*AMO_W +: AMO_W];
        sel_size = bus.in_req_size[i*3 +: 3];
        sel_addr = bus.in_req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.in_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_oh  = NUM_REQ'(1) << grant_idx;
  assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
  assign resp_done = bus.out_resp_val && bus.in_resp_ack[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      req_type_q <= '0;
      req_amo_q  <= '0;
      req_size_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_idx  <= win_idx;
            req_type_q <= sel_type;
            req_amo_q  <= sel_amo;
            req_size_q <= sel_size;
            req_addr_q <= sel_addr;
            req_data_q <= sel_data;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.out_req_ack) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_done) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Downstream payload comes only from the latched registers, so a requester
  // dropping valid while in S_REQ still sees its request issued and acked.
  assign bus.out_req_valid  = (state == S_REQ);
  assign bus.out_req_type   = req_type_q;
  assign bus.out_req_amo_op = req_amo_q;
  assign bus.out_req_size   = req_size_q;
  assign bus.out_req_addr   = req_addr_q;
  assign bus.out_req_data   = req_data_q;

  assign bus.in_req_ack   = ((state == S_REQ) && bus.out_req_ack) ? grant_oh : '0;
  assign bus.in_resp_val  = ((state == S_RESP) && bus.out_resp_val) ? grant_oh : '0;
  assign bus.out_resp_ack = (state == S_RESP) && bus.in_resp_ack[grant_idx];
  assign bus.in_resp_type = bus.out_resp_type;
  assign bus.in_resp_data = bus.out_resp_data;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tri_l2_rr_arbiter.sv
// Scoreboard bench for tri_l2_rr_arbiter: a transaction-level round-robin model predicts
// grant order and payload per batch of requests; a monitor checks every DUT handshake.
module tb_tri_l2_rr_arbiter;
  localparam int N      = 4;
  localparam int IDX_W  = 2;
  localparam int ADDR_W = 40;
  localparam int DATA_W = 64;
  localparam int TYPE_W = 5;
  localparam int AMO_W  = 4;

  typedef struct {
    int                idx;
    logic [TYPE_W-1:0] typ;
    logic [AMO_W-1:0]  amo;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [IDX_W-1:0] grant_idx;

  tri_l2_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .TYPE_W(TYPE_W), .AMO_W(AMO_W)) bus ();

  tri_l2_rr_arbiter #(.NUM_REQ(N), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .TYPE_W(TYPE_W), .AMO_W(AMO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester payloads (main writes), pending tracked as request/ack sequence numbers.
  logic [TYPE_W-1:0] p_type [N];
  logic [AMO_W-1:0]  p_amo  [N];
  logic [2:0]        p_size [N];
  logic [ADDR_W-1:0] p_addr [N];
  logic [DATA_W-1:0] p_data [N];
  int req_seq [N];
  int ack_seq [N];

  exp_t sb_q[$];
  int   ptr_model;
  int   checks;
  int   errors;
  int   ds_mode;   // 0 random, 1 immediate acks, 2 response stall

  // Monitor-owned state
  int          mon_phase;
  int          mon_cur;
  int          mon_cyc;
  int          last_fire_cyc;
  bit          prev_fire_valid;
  bit          expect_idle;
  int          resp_cycles;
  int          last_resp_cycles;
  logic        smp_req_fire;
  logic        smp_resp_fire;
  logic [N-1:0] smp_in_req_ack;

  // Driver-owned state
  int ds_state;
  int stall_cnt;

  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives all DUT inputs, once per cycle just after the active edge.
  initial begin
    ds_state  = 0;
    stall_cnt = 0;
    bus.in_req_valid = '0; bus.in_req_type = '0; bus.in_req_amo_op = '0;
    bus.in_req_size = '0; bus.in_req_addr = '0; bus.in_req_data = '0;
    bus.in_resp_ack = '0; bus.out_req_ack = 1'b0; bus.out_resp_val = 1'b0;
    bus.out_resp_type = '0; bus.out_resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ds_state = 0;
        bus.in_req_valid = '0;
        bus.in_resp_ack  = '0;
        bus.out_req_ack  = 1'b0;
        bus.out_resp_val = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) if (smp_in_req_ack[i]) ack_seq[i]++;
        if (smp_resp_fire) ds_state = 0;
        if (smp_req_fire) begin
          ds_state  = 1;
          stall_cnt = 5;
        end
        for (int i = 0; i < N; i++) begin
          bus.in_req_valid[i] = (req_seq[i] != ack_seq[i]);
          bus.in_req_type[i*TYPE_W +: TYPE_W]   = p_type[i];
          bus.in_req_amo_op[i*AMO_W +: AMO_W]   = p_amo[i];
          bus.in_req_size[i*3 +: 3]             = p_size[i];
          bus.in_req_addr[i*ADDR_W +: ADDR_W]   = p_addr[i];
          bus.in_req_data[i*DATA_W +: DATA_W]   = p_data[i];
        end
        bus.out_resp_type = TYPE_W'($urandom);
        bus.out_resp_data = {$urandom, $urandom};
        case (ds_mode)
          1: begin
            bus.out_req_ack  = 1'b1;
            bus.out_resp_val = (ds_state == 1);
            bus.in_resp_ack  = '1;
          end
          2: begin
            bus.out_req_ack  = 1'b1;
            bus.out_resp_val = (ds_state == 1);
            if (ds_state == 1 && stall_cnt > 0) begin
              bus.in_resp_ack = '0;
              stall_cnt--;
            end else begin
              bus.in_resp_ack = '1;
            end
          end
          default: begin
            bus.out_req_ack  = (ds_state == 0) && ($urandom_range(0, 2) == 0);
            bus.out_resp_val = (ds_state == 1) ? ($urandom_range(0, 1) == 1)
                                               : ($urandom_range(0, 4) == 0);
            bus.in_resp_ack  = N'($urandom);
          end
        endcase
      end
    end
  end

  // Monitor: checks on the falling edge, pops the scoreboard on each request handshake.
  initial begin
    mon_phase = 0; mon_cur = 0; mon_cyc = 0; last_fire_cyc = 0;
    prev_fire_valid = 0; expect_idle = 0; resp_cycles = 0; last_resp_cycles = 0;
    smp_req_fire = 0; smp_resp_fire = 0; smp_in_req_ack = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_phase = 0; expect_idle = 0; prev_fire_valid = 0;
        smp_req_fire = 0; smp_resp_fire = 0; smp_in_req_ack = '0;
      end else begin
        mon_cyc++;
        smp_in_req_ack = bus.in_req_ack;
        smp_req_fire   = bus.out_req_valid && bus.out_req_ack;
        smp_resp_fire  = bus.out_resp_val && bus.out_resp_ack;
        if (expect_idle) begin
          chk("idle_gap_busy", busy, 0);
          chk("idle_gap_req_valid", bus.out_req_valid, 0);
          expect_idle = 0;
        end
        if (mon_phase == 1) begin
          resp_cycles++;
          chk("resp_busy", busy, 1);
          chk("in_resp_val", bus.in_resp_val, bus.out_resp_val ? oh(mon_cur) : '0);
          chk("out_resp_ack", bus.out_resp_ack, bus.in_resp_ack[mon_cur]);
          if (bus.out_resp_val) begin
            chk("in_resp_type", bus.in_resp_type, bus.out_resp_type);
            chk("in_resp_data", bus.in_resp_data, bus.out_resp_data);
          end
          if (bus.out_resp_val && bus.in_resp_ack[mon_cur]) begin
            mon_phase        = 0;
            last_resp_cycles = resp_cycles;
            expect_idle      = 1;
          end
        end else begin
          chk("stray_in_resp_val", bus.in_resp_val, 0);
          chk("stray_out_resp_ack", bus.out_resp_ack, 0);
        end
        if (bus.out_req_valid) begin
          if (sb_q.size() == 0) begin
            chk("req_unexpected", bus.out_req_valid, 0);
          end else if (bus.out_req_ack) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("grant_idx", grant_idx, e.idx);
            chk("in_req_ack", bus.in_req_ack, oh(e.idx));
            chk("req_type", bus.out_req_type, e.typ);
            chk("req_amo", bus.out_req_amo_op, e.amo);
            chk("req_size", bus.out_req_size, e.size);
            chk("req_addr", bus.out_req_addr, e.addr);
            chk("req_data", bus.out_req_data, e.data);
            if (prev_fire_valid) chk("b2b_spacing", mon_cyc - last_fire_cyc, 3);
            last_fire_cyc   = mon_cyc;
            prev_fire_valid = (ds_mode == 1) && (sb_q.size() != 0);
            mon_phase   = 1;
            mon_cur     = e.idx;
            resp_cycles = 0;
          end else begin
            chk("req_ack_wait", bus.in_req_ack, 0);
          end
        end else begin
          chk("req_ack_no_valid", bus.in_req_ack, 0);
        end
      end
    end
  end

  task automatic raise(int i, logic [TYPE_W-1:0] t, logic [AMO_W-1:0] a, logic [2:0] s,
                       logic [ADDR_W-1:0] ad, logic [DATA_W-1:0] d);
    p_type[i] = t; p_amo[i] = a; p_size[i] = s; p_addr[i] = ad; p_data[i] = d;
    req_seq[i]++;
  endtask

  task automatic raise_rand(logic [N-1:0] set);
    for (int i = 0; i < N; i++)
      if (set[i]) raise(i, TYPE_W'($urandom), AMO_W'($urandom), 3'($urandom),
                        {8'($urandom), $urandom}, {$urandom, $urandom});
  endtask

  // Reference: requesters served in cyclic order starting at the model pointer.
  task automatic expect_order(logic [N-1:0] set);
    int last;
    last = ptr_model;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_model + k) % N;
      if (set[i]) begin
        sb_q.push_back('{i, p_type[i], p_amo[i], p_size[i], p_addr[i], p_data[i]});
        last = i;
      end
    end
    ptr_model = (last + 1) % N;
  endtask

  task automatic wait_done();
    int  n;
    bit  pend;
    n = 0;
    forever begin
      pend = 0;
      for (int i = 0; i < N; i++) if (req_seq[i] != ack_seq[i]) pend = 1;
      if ((!pend && sb_q.size() == 0 && mon_phase == 0) || n >= 600) break;
      @(posedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required=done pending_q=%0d", n, sb_q.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0; errors = 0; ptr_model = 0; ds_mode = 0;
    for (int i = 0; i < N; i++) begin
      req_seq[i] = 0; ack_seq[i] = 0;
      p_type[i] = '0; p_amo[i] = '0; p_size[i] = '0; p_addr[i] = '0; p_data[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_out_req_valid", bus.out_req_valid, 0);
    chk("rst_out_req_addr", bus.out_req_addr, 0);
    chk("rst_in_req_ack", bus.in_req_ack, 0);
    chk("rst_in_resp_val", bus.in_resp_val, 0);
    chk("rst_out_resp_ack", bus.out_resp_ack, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // All requesters at once, immediate downstream: order 0,1,2,3 then 0 again.
    ds_mode = 1;
    raise_rand(4'hF);
    expect_order(4'hF);
    wait_done();
    raise_rand(4'h1);
    expect_order(4'h1);
    wait_done();

    // Single requester 2, store to 0x1000; valid must appear one cycle after the request.
    ds_mode = 0;
    raise(2, 5'h1, 4'h0, 3'd3, 40'h1000, 64'hAB);
    expect_order(4'b0100);
    begin
      int n;
      n = 0;
      while (!bus.in_req_valid[2] && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("lat_valid_before", bus.out_req_valid, 0);
      @(negedge clk);
      chk("lat_valid_after", bus.out_req_valid, 1);
      chk("lat_addr", bus.out_req_addr, 40'h1000);
      chk("lat_data", bus.out_req_data, 64'hAB);
    end
    wait_done();

    // Wrap-around: serve 1 alone (pointer moves to 2), then 1 and 3 together -> 3 first.
    raise_rand(4'b0010);
    expect_order(4'b0010);
    wait_done();
    raise_rand(4'b1010);
    expect_order(4'b1010);
    wait_done();

    // Response stall: five cycles of response without requester ack.
    ds_mode = 2;
    raise_rand(4'b0001);
    expect_order(4'b0001);
    wait_done();
    chk("stall_resp_cycles", last_resp_cycles, 6);

    // Reset while in S_RESP; afterwards requester 0 must win over 3.
    raise_rand(4'b1110);
    expect_order(4'b1110);
    begin
      int n;
      n = 0;
      while (mon_phase == 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      #1;
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_req_valid", bus.out_req_valid, 0);
      chk("mid_rst_grant_idx", grant_idx, 0);
      chk("mid_rst_in_resp_val", bus.in_resp_val, 0);
      chk("mid_rst_out_resp_ack", bus.out_resp_ack, 0);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) req_seq[i] = ack_seq[i];
    ptr_model = 0;
    ds_mode   = 0;
    rst_n     = 1'b1;
    raise_rand(4'b1001);
    expect_order(4'b1001);
    wait_done();

    // Randomised batches with random downstream timing and stray responses.
    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] set;
      set     = N'($urandom_range(1, (1 << N) - 1));
      ds_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      raise_rand(set);
      expect_order(set);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
